exu_branch_unit: RTL

- Pipelined, parametrised successor to the combinational branch handler in the EXU.
- Accepts one pre-decoded control-transfer op per cycle (BRANCH/JAL/JALR) over a valid/ready handshake and resolves it into a registered response: taken, target, prediction check, link write-back and exception flags.
- Issues a frontend redirect on mispredict, then stalls for a configurable drain window.
- Keeps saturating branch/mispredict counters for perf monitoring.

---
 rtl/exu_branch_unit.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/exu_branch_unit.sv
`default_nettype none
// ============================================================================
// exu_branch_unit : pipelined BRANCH/JAL/JALR resolver with redirect + drain
// Revision 1.0
// ============================================================================
module exu_branch_unit #(
    parameter int XLEN      = 32,
    parameter int PC_W      = 32,
    parameter int C_EXT     = 0,
    parameter int DRAIN_CYC = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_vld_i,
    output logic             req_rdy_o,
    input  logic [1:0]       req_kind_i,
    input  logic [2:0]       req_funct3_i,
    input  logic [PC_W-1:0]  req_pc_i,
    input  logic [XLEN-1:0]  req_imm_i,
    input  logic [XLEN-1:0]  req_rs1_i,
    input  logic [XLEN-1:0]  req_rs2_i,
    input  logic [4:0]       req_rd_i,
    input  logic             req_ilen2_i,
    input  logic             req_pred_taken_i,
    input  logic [PC_W-1:0]  req_pred_pc_i,
    input  logic             flush_i,
    output logic             rsp_vld_o,
    input  logic             rsp_rdy_i,
    output logic [PC_W-1:0]  rsp_pc_o,
    output logic [PC_W-1:0]  rsp_target_pc_o,
    output logic             rsp_taken_o,
    output logic             rsp_pred_true_o,
    output logic [1:0]       rsp_exc_o,
    output logic             gpr_wen_o,
    output logic [4:0]       gpr_waddr_o,
    output logic [XLEN-1:0]  gpr_wdata_o,
    output logic             redirect_vld_o,
    output logic [PC_W-1:0]  redirect_pc_o,
    output logic [CNT_W-1:0] cnt_br_o,
    output logic [CNT_W-1:0] cnt_mis_o
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    localparam logic [1:0] KIND_BR   = 2'd0;
    localparam logic [1:0] KIND_JAL  = 2'd1;
    localparam logic [1:0] KIND_JALR = 2'd2;
    localparam logic [1:0] KIND_RSV  = 2'd3;
    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYC);

    state_e           state_q, state_d;
    logic [3:0]       drain_q, drain_d;

    logic             rsp_vld_q;
    logic [PC_W-1:0]  rsp_pc_q, rsp_tgt_q;
    logic             rsp_taken_q, rsp_pt_q, rsp_link_en_q, rsp_redir_q;
    logic [1:0]       rsp_exc_q;
    logic [4:0]       rsp_rd_q;
    logic [XLEN-1:0]  rsp_link_q;
    logic [CNT_W-1:0] cnt_br_q, cnt_mis_q;

    logic             accept, rsp_hs, redirect;
    logic [PC_W-1:0]  step, seq_pc, rel_pc, jalr_pc, tgt;
    logic [XLEN-1:0]  jalr_sum;
    logic             cond, f3_ill, illegal, taken, misal, pred_true;
    logic [1:0]       exc;

    assign req_rdy_o = (state_q == ST_RUN) & (~rsp_vld_q | rsp_rdy_i) & ~flush_i;
    assign accept    = req_vld_i & req_rdy_o;
    // flush kills the handshake outright: no write-back, redirect or counting
    assign rsp_hs    = rsp_vld_q & rsp_rdy_i & ~flush_i;
    assign redirect  = rsp_hs & rsp_redir_q;

    assign step     = ((C_EXT != 0) && req_ilen2_i) ? PC_W'(2) : PC_W'(4);
    assign seq_pc   = req_pc_i + step;
    assign rel_pc   = req_pc_i + req_imm_i[PC_W-1:0];
    assign jalr_sum = req_rs1_i + req_imm_i;
    assign jalr_pc  = jalr_sum[PC_W-1:0] & ~PC_W'(1);

    always_comb begin
        cond   = 1'b0;
        f3_ill = 1'b0;
        case (req_funct3_i)
            3'b000:  cond = (req_rs1_i == req_rs2_i);
            3'b001:  cond = (req_rs1_i != req_rs2_i);
            3'b100:  cond = ($signed(req_rs1_i) <  $signed(req_rs2_i));
            3'b101:  cond = ($signed(req_rs1_i) >= $signed(req_rs2_i));
            3'b110:  cond = (req_rs1_i <  req_rs2_i);
            3'b111:  cond = (req_rs1_i >= req_rs2_i);
            default: f3_ill = 1'b1;
        endcase

        illegal = (req_kind_i == KIND_RSV) | ((req_kind_i == KIND_BR) & f3_ill);
        taken   = 1'b0;
        tgt     = seq_pc;
        case (req_kind_i)
            KIND_BR: begin
                taken = cond & ~f3_ill;
                tgt   = taken ? rel_pc : seq_pc;
            end
            KIND_JAL: begin
                taken = 1'b1;
                tgt   = rel_pc;
            end
            KIND_JALR: begin
                taken = 1'b1;
                tgt   = jalr_pc;
            end
            default: begin
                taken = 1'b0;
                tgt   = seq_pc;
            end
        endcase

        misal     = taken & tgt[1] & (C_EXT == 0);
        exc       = {illegal, misal};
        pred_true = taken ? (req_pred_taken_i & (tgt == req_pred_pc_i)) : ~req_pred_taken_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld_q     <= 1'b0;
            rsp_pc_q      <= '0;
            rsp_tgt_q     <= '0;
            rsp_taken_q   <= 1'b0;
            rsp_pt_q      <= 1'b0;
            rsp_exc_q     <= 2'b00;
            rsp_link_en_q <= 1'b0;
            rsp_redir_q   <= 1'b0;
            rsp_rd_q      <= 5'd0;
            rsp_link_q    <= '0;
        end else if (flush_i) begin
            rsp_vld_q <= 1'b0;
        end else if (accept) begin
            rsp_vld_q     <= 1'b1;
            rsp_pc_q      <= req_pc_i;
            rsp_tgt_q     <= tgt;
            rsp_taken_q   <= taken;
            rsp_pt_q      <= pred_true;
            rsp_exc_q     <= exc;
            rsp_link_en_q <= ((req_kind_i == KIND_JAL) | (req_kind_i == KIND_JALR))
                             & (req_rd_i != 5'd0) & (exc == 2'b00);
            rsp_redir_q   <= ~pred_true & (exc == 2'b00);
            rsp_rd_q      <= req_rd_i;
            rsp_link_q    <= XLEN'(seq_pc);
        end else if (rsp_hs) begin
            rsp_vld_q <= 1'b0;
        end
    end

    // Drain count is loaded with DRAIN_CYC so req_rdy stays low exactly that many cycles
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        if (flush_i) begin
            state_d = ST_RUN;
            drain_d = 4'd0;
        end else if (state_q == ST_RUN) begin
            if (redirect && (DRAIN_INIT != 4'd0)) begin
                state_d = ST_DRAIN;
                drain_d = DRAIN_INIT;
            end
        end else begin
            drain_d = drain_q - 4'd1;
            if (drain_q <= 4'd1) begin
                state_d = ST_RUN;
                drain_d = 4'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            drain_q   <= 4'd0;
            cnt_br_q  <= '0;
            cnt_mis_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            if (rsp_hs && (rsp_exc_q == 2'b00) && !(&cnt_br_q))
                cnt_br_q <= cnt_br_q + 1'b1;
            if (redirect && !(&cnt_mis_q))
                cnt_mis_q <= cnt_mis_q + 1'b1;
        end
    end

    assign rsp_vld_o       = rsp_vld_q;
    assign rsp_pc_o        = rsp_pc_q;
    assign rsp_target_pc_o = rsp_tgt_q;
    assign rsp_taken_o     = rsp_taken_q;
    assign rsp_pred_true_o = rsp_pt_q;
    assign rsp_exc_o       = rsp_exc_q;
    assign gpr_wen_o       = rsp_hs & rsp_link_en_q;
    assign gpr_waddr_o     = rsp_rd_q;
    assign gpr_wdata_o     = rsp_link_q;
    assign redirect_vld_o  = redirect;
    assign redirect_pc_o   = rsp_tgt_q;
    assign cnt_br_o        = cnt_br_q;
    assign cnt_mis_o       = cnt_mis_q;

endmodule
`default_nettype wire
